spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- Parametrised SPI data-path engine.
- Serialises a transmit word onto mosi and deserialises miso into a receive word.
- Frame length is runtime-selectable up to DW bits; bit order is LSB- or MSB-first; all four CPOL/CPHA modes are supported.
- Sits between the SPI control/baud generator, which supplies the edge strobes and ss, and the APB register interface.
- Adds frame counting, completion and abort signalling, and short-frame justification.

Parameters:
- DW, 8: maximum frame width in bits; legal range 4..32.
- LW, $clog2(DW+1): width of frame_len.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- ss  in  1  slave select, active low; high means idle.
- load  in  1  one-cycle pulse; capture tx_data and frame_len and arm a frame.
- tx_data  in  DW  transmit word, right-justified.
- frame_len  in  LW  bits per frame; 0 or >DW is treated as DW.
- lsbfe  in  1  1 = LSB first.
- cpol, cpha  in  1 each  SPI mode.
- flag_high, flags_high, flag_low, flags_low  in  1 each  one-cycle strobes for high/low sample and shift edges from the baud generator.
- miso  in  1  serial input.
- mosi  out  1  serial output.
- busy  out  1  frame armed and not yet complete.
- rx_data  out  DW  last completed receive word, right-justified, upper bits zero.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_done  out  1  one-cycle pulse at frame completion; coincident with rx_valid.
- abort  out  1  one-cycle pulse when ss rises while busy.

Behaviour:
- Reset values: mosi=0, busy=0, rx_data=0, rx_valid=0, frame_done=0, abort=0. All internal counters and registers clear.
- Strobe selection:
  - sample_stb = (cpha^cpol) ? flag_high : flag_low.
  - shift_stb = (cpha^cpol) ? flags_high : flags_low.
- States: IDLE, ARMED, XFER.
- IDLE to ARMED on load:
  - Latch tx_data and effective length N.
  - tx_idx=0, rx_idx=0, rx shift word cleared, busy=1.
  - mosi = first bit: lsbfe ? tx_data[0] : tx_data[N-1]. Registered, so visible the cycle after load.
- ARMED to XFER on the first sample_stb or shift_stb with ss=0.
  - For cpha=1, the first shift_stb of a frame is consumed without advancing tx_idx, because the first bit is already on mosi.
- Shift rule: on shift_stb with ss=0 and busy, tx_idx++ and mosi = bit at position (lsbfe ? tx_idx+1 : N-2-tx_idx). Once tx_idx reaches N-1, mosi holds its value.
- Sample rule: on sample_stb with ss=0 and busy, write miso to position (lsbfe ? rx_idx : N-1-rx_idx) of the rx word, then rx_idx++.
- Completion: on the sample that makes rx_idx==N:
  - Next cycle: rx_data = assembled word, rx_valid=1 and frame_done=1 for exactly one cycle.
  - busy=0; return to IDLE.
- Simultaneous strobes: when sample_stb and shift_stb are both asserted in one cycle, sample is applied first and shift second, in the same cycle.
- load while busy is ignored. load coincident with completion is accepted: the completion pulses still fire and the new frame is armed.
- Abort: ss rises in ARMED or XFER.
  - abort pulses for 1 cycle, busy=0, return to IDLE.
  - rx_data is unchanged and rx_valid is not asserted.
- Strobes while ss=1 or in IDLE have no effect.
- Reset asserted mid-frame returns everything to reset values immediately, asynchronously.
- lsbfe, cpol and cpha are sampled live. Changing them while busy is illegal; the result is undefined but must not hang (busy clears on ss high).

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, ARMED, XFER);
  - the function eff_len(frame_len, DW);
  - the bit-position helper function for index mapping.
- One sub-module, spi_edge_sel, maps cpol/cpha and the four flags to sample_stb/shift_stb. It is reusable by the baud generator checker.

Test Plan:
- DW=8, mode 0, MSB-first, load tx=0xA5, N=8, miso driven 0x3C → mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; a single rx_valid pulse one cycle after the 8th sample.
- DW=16, mode 3, LSB-first, tx=0x1234, N=12, miso=0xABC LSB-first → mosi emits 0x234 LSB-first; rx_data=0x0ABC; upper bits 0.
- Mode 1 (cpha=1), N=8 → the first shift_stb leaves mosi unchanged; exactly 8 distinct bits are emitted; frame_done after the 8th sample.
- ss raised after 3 samples of an 8-bit frame → abort pulse, busy=0, rx_data keeps its previous 0x3C, no rx_valid.
- frame_len=0 and frame_len=DW+3 → both behave as N=DW. load while busy → ignored; the original tx word completes.
- PRESETn asserted mid-XFER with mosi=1 → all outputs 0 at once. A new load after release transfers correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and index helpers for the SPI shift engine and its helpers.
package spi_pkg;

  // Frame sequencer states: waiting for load, armed for the first edge,
  // and transferring bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2
  } spi_state_t;

  // Effective frame length: zero or anything wider than the data path
  // means a full-width frame.
  function automatic int eff_len(input int frame_len, input int dw);
    if (frame_len == 0 || frame_len > dw) begin
      return dw;
    end
    return frame_len;
  endfunction

  // Maps the idx-th bit on the wire to its position in a right-justified
  // word of length len, for either bit order.
  function automatic int bit_pos(input logic lsbfe, input int idx, input int len);
    return lsbfe ? idx : (len - 1 - idx);
  endfunction

endpackage

// File: rtl/spi_edge_sel.sv
// Selects the sample and shift strobes for the active CPOL/CPHA mode.
// Modes where cpol and cpha differ sample on the "high" flags, the others
// on the "low" flags.
module spi_edge_sel (
  input  logic cpol,
  input  logic cpha,
  input  logic flag_high,
  input  logic flags_high,
  input  logic flag_low,
  input  logic flags_low,
  output logic sample_stb,
  output logic shift_stb
);

  logic odd_mode;

  assign odd_mode   = cpha ^ cpol;
  assign sample_stb = odd_mode ? flag_high  : flag_low;
  assign shift_stb  = odd_mode ? flags_high : flags_low;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI data-path engine: serialises a transmit word onto mosi, assembles
// miso into a right-justified receive word, and reports completion/abort.
// Edge timing comes from the external baud generator via four strobes.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = $clog2(DW + 1)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          ss,
  input  logic          load,
  input  logic [DW-1:0] tx_data,
  input  logic [LW-1:0] frame_len,
  input  logic          lsbfe,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          flag_high,
  input  logic          flags_high,
  input  logic          flag_low,
  input  logic          flags_low,
  input  logic          miso,
  output logic          mosi,
  output logic          busy,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_done,
  output logic          abort
);

  localparam int            IW  = $clog2(DW);
  localparam logic [LW-1:0] ONE = LW'(1);

  logic          sample_stb;
  logic          shift_stb;

  spi_state_t    state_reg;
  logic [DW-1:0] tx_word_reg;
  logic [DW-1:0] rx_word_reg;
  logic [DW-1:0] rx_data_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] tx_idx_reg;
  logic [LW-1:0] rx_idx_reg;
  logic          first_shift_reg;
  logic          ss_q_reg;
  logic          mosi_reg;
  logic          busy_reg;
  logic          rx_valid_reg;
  logic          frame_done_reg;
  logic          abort_reg;

  logic [LW-1:0] len_new;
  logic [IW-1:0] first_pos;
  logic [IW-1:0] tx_pos;
  logic [IW-1:0] rx_pos;
  logic [DW-1:0] rx_word_next;
  logic          ss_rise;
  logic          do_sample;
  logic          do_shift;
  logic          rx_last;
  logic          tx_more;
  logic          shift_skip;
  logic          completing;
  logic          arm;

  spi_edge_sel u_edge_sel (
    .cpol       (cpol),
    .cpha       (cpha),
    .flag_high  (flag_high),
    .flags_high (flags_high),
    .flag_low   (flag_low),
    .flags_low  (flags_low),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  // Index mapping, strobe qualification and next-word assembly.
  always_comb begin
    len_new      = LW'(eff_len(int'(frame_len), DW));
    first_pos    = IW'(bit_pos(lsbfe, 0, int'(len_new)));
    tx_pos       = IW'(bit_pos(lsbfe, int'(tx_idx_reg) + 1, int'(len_reg)));
    rx_pos       = IW'(bit_pos(lsbfe, int'(rx_idx_reg), int'(len_reg)));
    rx_word_next = rx_word_reg;
    rx_word_next[rx_pos] = miso;
    // ss_q_reg idles high so a load straight out of reset is not seen as an abort.
    ss_rise      = ss & ~ss_q_reg;
    do_sample    = busy_reg & ~ss & sample_stb;
    do_shift     = busy_reg & ~ss & shift_stb;
    rx_last      = (rx_idx_reg + ONE) == len_reg;
    tx_more      = (tx_idx_reg + ONE) < len_reg;
    // With cpha=1 the leading edge is a shift, but bit 0 is already on mosi.
    shift_skip   = first_shift_reg & cpha;
    completing   = do_sample & rx_last;
    // A load on the completing cycle chains straight into the next frame.
    arm          = load & (~busy_reg | completing);
  end

  // Frame sequencer with registered outputs; sample is applied before shift
  // when both strobes land in the same cycle (they touch disjoint state).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      tx_word_reg     <= '0;
      rx_word_reg     <= '0;
      rx_data_reg     <= '0;
      len_reg         <= '0;
      tx_idx_reg      <= '0;
      rx_idx_reg      <= '0;
      first_shift_reg <= 1'b0;
      ss_q_reg        <= 1'b1;
      mosi_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      rx_valid_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      abort_reg      <= 1'b0;
      ss_q_reg       <= ss;

      case (state_reg)
        IDLE: begin
        end
        ARMED, XFER: begin
          if (ss_rise) begin
            abort_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            if (do_sample || do_shift) begin
              state_reg <= XFER;
            end
            if (do_sample) begin
              rx_word_reg <= rx_word_next;
              rx_idx_reg  <= rx_idx_reg + ONE;
              if (rx_last) begin
                rx_data_reg    <= rx_word_next;
                rx_valid_reg   <= 1'b1;
                frame_done_reg <= 1'b1;
                busy_reg       <= 1'b0;
                state_reg      <= IDLE;
              end
            end
            if (do_shift) begin
              first_shift_reg <= 1'b0;
              // After the last bit has been presented mosi simply holds.
              if (!shift_skip && tx_more) begin
                tx_idx_reg <= tx_idx_reg + ONE;
                mosi_reg   <= tx_word_reg[tx_pos];
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (arm) begin
        state_reg       <= ARMED;
        busy_reg        <= 1'b1;
        tx_word_reg     <= tx_data;
        len_reg         <= len_new;
        tx_idx_reg      <= '0;
        rx_idx_reg      <= '0;
        rx_word_reg     <= '0;
        first_shift_reg <= 1'b1;
        mosi_reg        <= tx_data[first_pos];
      end
    end
  end

  assign mosi       = mosi_reg;
  assign busy       = busy_reg;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign frame_done = frame_done_reg;
  assign abort      = abort_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: an 8-bit and a 16-bit instance share the
// serial stimulus; a frame-level model predicts mosi bits and rx words.
module tb_spi_shift_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ss, load, lsbfe, cpol, cpha, miso;
  logic        flag_high, flags_high, flag_low, flags_low;
  logic [15:0] tx_data;
  logic [3:0]  frame_len8;
  logic [4:0]  frame_len16;

  logic        mosi8, busy8, rxv8, done8, abort8;
  logic [7:0]  rx8;
  logic        mosi16, busy16, rxv16, done16, abort16;
  logic [15:0] rx16;

  spi_shift_engine #(.DW(8)) u_dut8 (
    .PCLK(clk), .PRESETn(rst_n), .ss(ss), .load(load), .tx_data(tx_data[7:0]),
    .frame_len(frame_len8), .lsbfe(lsbfe), .cpol(cpol), .cpha(cpha),
    .flag_high(flag_high), .flags_high(flags_high), .flag_low(flag_low), .flags_low(flags_low),
    .miso(miso), .mosi(mosi8), .busy(busy8), .rx_data(rx8), .rx_valid(rxv8),
    .frame_done(done8), .abort(abort8)
  );

  spi_shift_engine #(.DW(16)) u_dut16 (
    .PCLK(clk), .PRESETn(rst_n), .ss(ss), .load(load), .tx_data(tx_data),
    .frame_len(frame_len16), .lsbfe(lsbfe), .cpol(cpol), .cpha(cpha),
    .flag_high(flag_high), .flags_high(flags_high), .flag_low(flag_low), .flags_low(flags_low),
    .miso(miso), .mosi(mosi16), .busy(busy16), .rx_data(rx16), .rx_valid(rxv16),
    .frame_done(done16), .abort(abort16)
  );

  logic        mosi_v[2], busy_v[2], rxv_v[2], done_v[2], abort_v[2];
  logic [15:0] rx_v[2];
  assign mosi_v[0] = mosi8;   assign mosi_v[1] = mosi16;
  assign busy_v[0] = busy8;   assign busy_v[1] = busy16;
  assign rxv_v[0]  = rxv8;    assign rxv_v[1]  = rxv16;
  assign done_v[0] = done8;   assign done_v[1] = done16;
  assign abort_v[0] = abort8; assign abort_v[1] = abort16;
  assign rx_v[0]   = {8'h00, rx8};
  assign rx_v[1]   = rx16;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] prev_rx[2];

  function automatic int model_len(input int fl, input int dw);
    return (fl == 0 || fl > dw) ? dw : fl;
  endfunction

  function automatic logic tx_bit(input logic [15:0] w, input logic lsb, input int n, input int k);
    return lsb ? w[k] : w[n - 1 - k];
  endfunction

  // Drives the selected strobes; the unselected pair gets random noise.
  task automatic drive_flags(input bit s, input bit h, input bit hi);
    if (hi) begin
      flag_high = s; flags_high = h;
      flag_low = 1'($urandom_range(0, 1)); flags_low = 1'($urandom_range(0, 1));
    end else begin
      flag_low = s; flags_low = h;
      flag_high = 1'($urandom_range(0, 1)); flags_high = 1'($urandom_range(0, 1));
    end
  endtask

  // One frame on both instances; ops are the SPI edge order for the mode.
  task automatic run_frame(input logic [15:0] tx, input int fl8, input int fl16,
                           input logic lsb, input logic pol, input logic pha,
                           input bit use_miso, input logic [15:0] miso_word,
                           input int abort_after, input int stray_at,
                           input bit chain, input logic [15:0] chain_tx,
                           input bit preloaded, input string name);
    int n[2];
    logic [15:0] rx_exp[2];
    bit fin[2];
    int bad_pulse[2];
    int bad_abort[2];
    int ops[$];
    int nmax, ksamp, shifts, e, pos;
    bit hi, do_s, do_h, last_op, pulse, exp_busy;
    logic mb;

    n[0] = model_len(fl8, 8);
    n[1] = model_len(fl16, 16);
    nmax = (n[0] > n[1]) ? n[0] : n[1];
    hi = pol ^ pha;
    for (int d = 0; d < 2; d++) begin
      rx_exp[d] = '0; fin[d] = 0; bad_pulse[d] = 0; bad_abort[d] = 0;
    end
    lsbfe = lsb; cpol = pol; cpha = pha;
    if (!preloaded) begin
      @(negedge clk);
      ss = 1'b1; tx_data = tx; frame_len8 = fl8[3:0]; frame_len16 = fl16[4:0]; load = 1'b1;
      drive_flags(0, 0, hi);
      @(negedge clk);
      load = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b1) begin
        failures++; $display("FAIL %s dut%0d busy_after_load got=%b exp=1", name, d, busy_v[d]);
      end
      checks++;
      if (mosi_v[d] !== tx_bit(tx, lsb, n[d], 0)) begin
        failures++; $display("FAIL %s dut%0d first_mosi got=%b exp=%b", name, d, mosi_v[d], tx_bit(tx, lsb, n[d], 0));
      end
    end
    ss = 1'b0;

    for (int k = 0; k < nmax; k++) begin
      if (pha) begin ops.push_back(2); ops.push_back(1); end
      else begin ops.push_back(1); if (k < nmax - 1) ops.push_back(2); end
    end

    ksamp = 0; shifts = 0;
    for (int i = 0; i < ops.size(); i++) begin
      do_s = (ops[i] == 1);
      do_h = (ops[i] == 2);
      if (do_s && ksamp == abort_after) break;
      if (do_s && ksamp == stray_at) begin
        tx_data = ~tx; frame_len8 = 4'd3; frame_len16 = 5'd3; load = 1'b1;
        drive_flags(0, 0, hi);
        @(negedge clk);
        load = 1'b0;
      end
      if (do_s && (i + 1 < ops.size()) && ops[i + 1] == 2 && $urandom_range(0, 1) == 1) begin
        do_h = 1; i++;
      end
      last_op = (i == ops.size() - 1);
      mb = use_miso ? miso_word[lsb ? ksamp : nmax - 1 - ksamp] : 1'($urandom_range(0, 1));
      if (do_s) begin
        for (int d = 0; d < 2; d++) begin
          if (!fin[d]) begin
            e = shifts - (pha ? 1 : 0);
            if (e < 0) e = 0;
            if (e > n[d] - 1) e = n[d] - 1;
            checks++;
            if (mosi_v[d] !== tx_bit(tx, lsb, n[d], e)) begin
              failures++;
              $display("FAIL %s dut%0d mosi_bit%0d got=%b exp=%b", name, d, ksamp, mosi_v[d], tx_bit(tx, lsb, n[d], e));
            end
          end
        end
      end
      miso = mb;
      if (chain && last_op) begin load = 1'b1; tx_data = chain_tx; end
      drive_flags(do_s, do_h, hi);
      @(negedge clk);
      load = 1'b0;
      drive_flags(0, 0, hi);
      if (do_h) shifts++;
      for (int d = 0; d < 2; d++) begin
        pulse = 0;
        if (do_s && !fin[d]) begin
          pos = lsb ? ksamp : n[d] - 1 - ksamp;
          rx_exp[d][pos] = mb;
          pulse = (ksamp + 1 == n[d]);
        end
        if (rxv_v[d] !== pulse || done_v[d] !== pulse) bad_pulse[d]++;
        if (abort_v[d] !== 1'b0) bad_abort[d]++;
        if (pulse) begin
          fin[d] = 1;
          prev_rx[d] = rx_exp[d];
          exp_busy = chain && last_op;
          checks++;
          if (rx_v[d] !== rx_exp[d]) begin
            failures++; $display("FAIL %s dut%0d rx_data got=%h exp=%h", name, d, rx_v[d], rx_exp[d]);
          end
          checks++;
          if (busy_v[d] !== exp_busy) begin
            failures++; $display("FAIL %s dut%0d busy_at_done got=%b exp=%b", name, d, busy_v[d], exp_busy);
          end
          if (exp_busy) begin
            checks++;
            if (mosi_v[d] !== tx_bit(chain_tx, lsb, n[d], 0)) begin
              failures++; $display("FAIL %s dut%0d chained_mosi got=%b exp=%b", name, d, mosi_v[d], tx_bit(chain_tx, lsb, n[d], 0));
            end
          end
        end
      end
      if (do_s) ksamp++;
      repeat ($urandom_range(0, 2)) begin
        drive_flags(0, 0, hi);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (rxv_v[d] !== 1'b0 || done_v[d] !== 1'b0) bad_pulse[d]++;
          if (abort_v[d] !== 1'b0) bad_abort[d]++;
        end
      end
    end

    if (abort_after >= 0) begin
      ss = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (abort_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || rxv_v[d] !== 1'b0) begin
          failures++;
          $display("FAIL %s dut%0d abort/busy/rx_valid got=%b%b%b exp=100", name, d, abort_v[d], busy_v[d], rxv_v[d]);
        end
        checks++;
        if (rx_v[d] !== prev_rx[d]) begin
          failures++; $display("FAIL %s dut%0d rx_kept got=%h exp=%h", name, d, rx_v[d], prev_rx[d]);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (abort_v[d] !== 1'b0) bad_abort[d]++;
    end else if (!chain) begin
      ss = 1'b1;
      repeat (2) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) if (abort_v[d] !== 1'b0 || rxv_v[d] !== 1'b0) bad_abort[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bad_pulse[d] != 0) begin
        failures++; $display("FAIL %s dut%0d rx_valid_timing bad_cycles=%0d exp=0", name, d, bad_pulse[d]);
      end
      checks++;
      if (bad_abort[d] != 0) begin
        failures++; $display("FAIL %s dut%0d stray_abort bad_cycles=%0d exp=0", name, d, bad_abort[d]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ss = 1'b1; load = 1'b0; tx_data = '0; frame_len8 = '0; frame_len16 = '0;
    lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
    drive_flags(0, 0, 0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mosi_v[d], busy_v[d], rxv_v[d], done_v[d], abort_v[d], rx_v[d]} !== 21'd0) begin
        failures++;
        $display("FAIL reset dut%0d outputs got=%b%b%b%b%b/%h exp=all zero", d, mosi_v[d], busy_v[d], rxv_v[d], done_v[d], abort_v[d], rx_v[d]);
      end
      prev_rx[d] = '0;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0_msb;
    run_frame(16'h00A5, 8, 8, 1'b0, 1'b0, 1'b0, 1, 16'h003C, -1, -1, 0, 16'h0, 0, "mode0_msb");
  endtask

  task automatic test_abort;
    run_frame(16'($urandom), 8, 8, 1'b0, 1'b0, 1'b0, 0, 16'h0, 3, -1, 0, 16'h0, 0, "abort");
  endtask

  task automatic test_mode3_lsb;
    run_frame(16'h1234, 12, 12, 1'b1, 1'b1, 1'b1, 1, 16'h0ABC, -1, -1, 0, 16'h0, 0, "mode3_lsb");
  endtask

  task automatic test_mode1;
    run_frame(16'($urandom), 8, 8, 1'b0, 1'b0, 1'b1, 0, 16'h0, -1, -1, 0, 16'h0, 0, "mode1");
  endtask

  task automatic test_len_extremes;
    run_frame(16'($urandom), 0, 0, 1'b0, 1'b1, 1'b0, 0, 16'h0, -1, -1, 0, 16'h0, 0, "len_zero");
    run_frame(16'($urandom), 11, 19, 1'b1, 1'b0, 1'b0, 0, 16'h0, -1, -1, 0, 16'h0, 0, "len_over");
  endtask

  task automatic test_load_while_busy;
    run_frame(16'($urandom), 8, 16, 1'b0, 1'b0, 1'b1, 0, 16'h0, -1, 2, 0, 16'h0, 0, "load_busy");
  endtask

  task automatic test_back_to_back;
    logic [15:0] t1, t2;
    t1 = 16'($urandom); t2 = 16'($urandom);
    run_frame(t1, 6, 6, 1'b0, 1'b0, 1'b0, 0, 16'h0, -1, -1, 1, t2, 0, "b2b_first");
    run_frame(t2, 6, 6, 1'b0, 1'b0, 1'b0, 0, 16'h0, -1, -1, 0, 16'h0, 1, "b2b_second");
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      run_frame(16'($urandom), $urandom_range(0, 11), $urandom_range(0, 19),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                0, 16'h0, -1, -1, 0, 16'h0, 0, "random");
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ss = 1'b1; tx_data = 16'hFFFF; frame_len8 = 4'd8; frame_len16 = 5'd16;
    lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0; load = 1'b1;
    drive_flags(0, 0, 0);
    @(negedge clk);
    load = 1'b0; ss = 1'b0;
    repeat (3) begin
      miso = 1'b1; drive_flags(1, 1, 0);
      @(negedge clk);
      drive_flags(0, 0, 0);
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mosi_v[d] !== 1'b1 || busy_v[d] !== 1'b1) begin
        failures++; $display("FAIL reset_mid dut%0d pre_reset mosi/busy got=%b%b exp=11", d, mosi_v[d], busy_v[d]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mosi_v[d], busy_v[d], rxv_v[d], done_v[d], abort_v[d], rx_v[d]} !== 21'd0) begin
        failures++;
        $display("FAIL reset_mid dut%0d async_clear got=%b%b%b%b%b/%h exp=all zero", d, mosi_v[d], busy_v[d], rxv_v[d], done_v[d], abort_v[d], rx_v[d]);
      end
      prev_rx[d] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1; ss = 1'b1;
    run_frame(16'($urandom), 8, 16, 1'b1, 1'b0, 1'b0, 0, 16'h0, -1, -1, 0, 16'h0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_abort();
    test_mode3_lsb();
    test_mode1();
    test_len_extremes();
    test_load_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
